// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmitter with Tx FIFO and per-character framing; optional line break via UART_TX_BREAK_EN
module uart_tx_engine #(
    parameter int MAX_UART_DATA_W = 9,
    parameter int FIFO_DEPTH      = 4,
    parameter int OVERSAMPLE      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 baud_en_i,
    input  logic                                 tx_en_i,
`ifdef UART_TX_BREAK_EN
    input  logic                                 tx_break_i,
`endif
    input  logic                                 tx_valid_i,
    output logic                                 tx_ready_o,
    input  logic [MAX_UART_DATA_W-1:0]           tx_data_i,
    input  logic [$clog2(MAX_UART_DATA_W+1)-1:0] data_w_i,
    input  logic [1:0]                           parity_mode_i,
    input  logic [1:0]                           stop_mode_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o,
    output logic                                 tx_busy_o,
    output logic                                 tx_done_o,
    output logic                                 uart_tx_o
);
    localparam int DW_W  = $clog2(MAX_UART_DATA_W + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SC_W  = $clog2(2 * OVERSAMPLE);
    localparam int BC_W  = $clog2(MAX_UART_DATA_W + 5);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`endif

    logic [MAX_UART_DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DW_W-1:0]            fifo_dw_q   [FIFO_DEPTH];
    logic [1:0]                 fifo_par_q  [FIFO_DEPTH];
    logic [1:0]                 fifo_stop_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic                       push, pop, full, empty;

    state_e                     state_q, state_d;
    logic [MAX_UART_DATA_W-1:0] frame_data_q, frame_data_d;
    logic [DW_W-1:0]            frame_dw_q, frame_dw_d;
    logic [1:0]                 frame_par_q, frame_par_d;
    logic [1:0]                 frame_stop_q, frame_stop_d;
    logic [SC_W-1:0]            sample_q, sample_d;
    logic [BC_W-1:0]            bit_q, bit_d;
    logic                       line_q, line_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [BC_W-1:0]            eff_w;
    logic [BC_W-1:0]            bit_nxt;
    logic [MAX_UART_DATA_W-1:0] data_mask;
    logic                       parity_bit;
    logic [SC_W-1:0]            stop_last;
    logic                       bit_end;

    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign push         = tx_valid_i & ~full;
    assign tx_ready_o   = ~full;
    assign fifo_count_o = count_q;
    assign tx_busy_o    = busy_q;
    assign tx_done_o    = done_q;
    assign uart_tx_o    = line_q;

    // Entry storage: validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= tx_data_i;
            fifo_dw_q[wr_ptr_q]   <= data_w_i;
            fifo_par_q[wr_ptr_q]  <= parity_mode_i;
            fifo_stop_q[wr_ptr_q] <= stop_mode_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame-derived helpers: clamped width, parity over the active bits, stop length
    always_comb begin
        if (frame_dw_q < DW_W'(5))                    eff_w = BC_W'(5);
        else if (frame_dw_q > DW_W'(MAX_UART_DATA_W)) eff_w = BC_W'(MAX_UART_DATA_W);
        else                                          eff_w = BC_W'(frame_dw_q);
        bit_nxt   = bit_q + BC_W'(1);
        data_mask = ~({MAX_UART_DATA_W{1'b1}} << eff_w);
        case (frame_par_q)
            2'b01:   parity_bit = ^(frame_data_q & data_mask);
            2'b10:   parity_bit = ~^(frame_data_q & data_mask);
            default: parity_bit = 1'b1;
        endcase
        case (frame_stop_q)
            2'b00:   stop_last = SC_W'(OVERSAMPLE - 1);
            2'b01:   stop_last = SC_W'(3 * OVERSAMPLE / 2 - 1);
            default: stop_last = SC_W'(2 * OVERSAMPLE - 1);
        endcase
        bit_end = (sample_q == SC_W'(OVERSAMPLE - 1));
    end

    // Frame sequencer registers; reset aborts any frame and parks the line high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            frame_data_q <= '0;
            frame_dw_q   <= '0;
            frame_par_q  <= '0;
            frame_stop_q <= '0;
            sample_q     <= '0;
            bit_q        <= '0;
            line_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_data_q <= frame_data_d;
            frame_dw_q   <= frame_dw_d;
            frame_par_q  <= frame_par_d;
            frame_stop_q <= frame_stop_d;
            sample_q     <= sample_d;
            bit_q        <= bit_d;
            line_q       <= line_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic: every transition waits for a baud tick
    always_comb begin
        state_d      = state_q;
        frame_data_d = frame_data_q;
        frame_dw_d   = frame_dw_q;
        frame_par_d  = frame_par_q;
        frame_stop_d = frame_stop_q;
        sample_d     = sample_q;
        bit_d        = bit_q;
        line_d       = line_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pop          = 1'b0;
        if (baud_en_i) begin
            case (state_q)
                ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (tx_break_i) begin
                        state_d  = ST_BREAK;
                        line_d   = 1'b0;
                        busy_d   = 1'b1;
                        sample_d = '0;
                        bit_d    = '0;
                    end else
`endif
                    if (tx_en_i && !empty) begin
                        pop          = 1'b1;
                        frame_data_d = fifo_data_q[rd_ptr_q];
                        frame_dw_d   = fifo_dw_q[rd_ptr_q];
                        frame_par_d  = fifo_par_q[rd_ptr_q];
                        frame_stop_d = fifo_stop_q[rd_ptr_q];
                        state_d      = ST_START;
                        line_d       = 1'b0;
                        busy_d       = 1'b1;
                        sample_d     = '0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_d  = ST_DATA;
                        sample_d = '0;
                        bit_d    = '0;
                        line_d   = frame_data_q[0];
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        sample_d = '0;
                        if (bit_q == eff_w - BC_W'(1)) begin
                            if (frame_par_q != 2'b00) begin
                                state_d = ST_PARITY;
                                line_d  = parity_bit;
                            end else begin
                                state_d = ST_STOP;
                                line_d  = 1'b1;
                            end
                        end else begin
                            bit_d  = bit_nxt;
                            line_d = |(frame_data_q & (MAX_UART_DATA_W'(1) << bit_nxt));
                        end
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d  = ST_STOP;
                        sample_d = '0;
                        line_d   = 1'b1;
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
                ST_STOP: begin
                    if (sample_q == stop_last) begin
                        state_d  = ST_IDLE;
                        sample_d = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (bit_end) begin
                        sample_d = '0;
                        // bit_q counts completed break periods, saturating once the minimum is met
                        if (!tx_break_i && bit_q >= BC_W'(MAX_UART_DATA_W + 3)) begin
                            state_d = ST_IDLE;
                            line_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else if (bit_q < BC_W'(MAX_UART_DATA_W + 3)) begin
                            bit_d = bit_nxt;
                        end
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - randomized self-checking bench for uart_tx_engine against a frame-level model
module tb_uart_tx_engine;
    localparam int MAXW  = 9;
    localparam int DEPTH = 4;
    localparam int OS    = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       baud_en_i;
    logic       tx_en_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [8:0] tx_data_i;
    logic [3:0] data_w_i;
    logic [1:0] parity_mode_i;
    logic [1:0] stop_mode_i;
    logic [2:0] fifo_count_o;
    logic       tx_busy_o;
    logic       tx_done_o;
    logic       uart_tx_o;
`ifdef UART_TX_BREAK_EN
    logic       tx_break_i;
`endif

    uart_tx_engine #(.MAX_UART_DATA_W(MAXW), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .baud_en_i(baud_en_i), .tx_en_i(tx_en_i),
`ifdef UART_TX_BREAK_EN
        .tx_break_i(tx_break_i),
`endif
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .data_w_i(data_w_i), .parity_mode_i(parity_mode_i), .stop_mode_i(stop_mode_i),
        .fifo_count_o(fifo_count_o), .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o),
        .uart_tx_o(uart_tx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int data;
        int w;
        int p;
        int s;
    } entry_t;

    entry_t mq[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     done_cnt = 0;
    int     obs[0:511];
    int     done_idx;
    int     gap;
    int     bdiv = 0;

    // Baud tick every third clock, changing on the falling edge
    initial begin
        baud_en_i = 1'b0;
        forever begin
            @(negedge clk_i);
            bdiv = (bdiv + 1) % 3;
            baud_en_i = (bdiv == 0);
        end
    end

    always @(negedge clk_i) if (tx_done_o === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic int eff_width(int w);
        return (w < 5) ? 5 : ((w > MAXW) ? MAXW : w);
    endfunction

    function automatic int stop_ticks(int s);
        return (s == 0) ? OS : ((s == 1) ? (OS * 3) / 2 : OS * 2);
    endfunction

    function automatic int par_val(entry_t e);
        int ones = 0;
        for (int i = 0; i < eff_width(e.w); i++) ones += (e.data >> i) & 1;
        if (e.p == 1) return ones % 2;
        if (e.p == 2) return 1 - (ones % 2);
        return 1;
    endfunction

    function automatic int exp_level(entry_t e, int k);
        int slot = k / OS;
        int w = eff_width(e.w);
        if (slot == 0) return 0;
        if (slot <= w) return (e.data >> (slot - 1)) & 1;
        if (e.p != 0 && slot == w + 1) return par_val(e);
        return 1;
    endfunction

    function automatic int frame_len(entry_t e);
        return OS * (1 + eff_width(e.w) + ((e.p != 0) ? 1 : 0)) + stop_ticks(e.s);
    endfunction

    task automatic next_tick();
        @(posedge clk_i);
        while (baud_en_i !== 1'b1) @(posedge clk_i);
        #1;
    endtask

    task automatic push(int d, int w, int p, int s);
        entry_t e;
        @(negedge clk_i);
        tx_valid_i = 1'b1;
        tx_data_i = d[8:0];
        data_w_i = w[3:0];
        parity_mode_i = p[1:0];
        stop_mode_i = s[1:0];
        if (mq.size() < DEPTH) begin
            e.data = d & 32'h1FF; e.w = w & 15; e.p = p & 3; e.s = s & 3;
            mq.push_back(e);
        end
        @(negedge clk_i);
        tx_valid_i = 1'b0;
    endtask

    task automatic check_frame(string name);
        entry_t e;
        int last, errs, waited, fk;
        logic exp_l, exp_b, got_l, got_b;
        done_idx = -1;
        n_cmp++;
        if (mq.size() == 0) begin
            n_fail++;
            $display("FAIL %s model: no queued entry, required one", name);
            return;
        end
        e = mq.pop_front();
        last = frame_len(e);
        waited = 0;
        do begin
            next_tick();
            waited++;
        end while (uart_tx_o !== 1'b0 && waited < 3000);
        gap = waited;
        if (uart_tx_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: line=%b after %0d ticks, required 0", name, uart_tx_o, waited);
            return;
        end
        errs = 0; fk = -1; exp_l = 0; exp_b = 0; got_l = 0; got_b = 0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) next_tick();
            obs[k] = (uart_tx_o === 1'b1) ? 1 : 0;
            if (tx_done_o === 1'b1 && done_idx < 0) done_idx = k;
            if (uart_tx_o !== (exp_level(e, k) != 0) || tx_busy_o !== (k < last)) begin
                if (errs == 0) begin
                    fk = k; got_l = uart_tx_o; got_b = tx_busy_o;
                    exp_l = (exp_level(e, k) != 0); exp_b = (k < last);
                end
                errs++;
            end
        end
        n_cmp++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s waveform: %0d bad ticks, first tick %0d line=%b busy=%b, required line=%b busy=%b",
                     name, errs, fk, got_l, got_b, exp_l, exp_b);
        end
        n_cmp++;
        if (done_idx != last) begin
            n_fail++;
            $display("FAIL %s done_tick: got %0d, required %0d", name, done_idx, last);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; tx_en_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = '0;
        data_w_i = 4'd8; parity_mode_i = 2'd0; stop_mode_i = 2'd0;
`ifdef UART_TX_BREAK_EN
        tx_break_i = 1'b0;
`endif
        repeat (4) @(posedge clk_i);
        #1;
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_fail++; $display("FAIL reset line: got %b, required 1", uart_tx_o); end
        n_cmp++; if (tx_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", tx_busy_o); end
        n_cmp++; if (tx_done_o !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b, required 0", tx_done_o); end
        n_cmp++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL reset count: got %0d, required 0", fifo_count_o); end
        n_cmp++; if (tx_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b, required 1", tx_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        push(32'h55, 8, 0, 0);
        tx_en_i = 1'b1;
        check_frame("basic_55");
        n_cmp++;
        if (done_idx != 160) begin n_fail++; $display("FAIL basic done_at: got %0d, required 160", done_idx); end
        tx_en_i = 1'b0;
    endtask

    task automatic test_parity();
        int exp_p[3] = '{1, 0, 1};
        for (int m = 1; m <= 3; m++) push(32'h1A3, 9, m, 0);
        tx_en_i = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            check_frame($sformatf("parity_m%0d", m));
            n_cmp++;
            if (obs[OS * 10 + OS / 2] != exp_p[m - 1]) begin
                n_fail++;
                $display("FAIL parity_bit mode %0d: got %0d, required %0d", m, obs[OS * 10 + OS / 2], exp_p[m - 1]);
            end
        end
        tx_en_i = 1'b0;
    endtask

    task automatic test_width_clamp();
        push(32'hFF, 3, 0, 0);
        push(32'hFF, 12, 0, 0);
        tx_en_i = 1'b1;
        check_frame("width_3");
        n_cmp++;
        if (done_idx != 112) begin n_fail++; $display("FAIL width_3 length: got %0d, required 112", done_idx); end
        check_frame("width_12");
        n_cmp++;
        if (done_idx != 176) begin n_fail++; $display("FAIL width_12 length: got %0d, required 176", done_idx); end
        tx_en_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        push(32'h0F, 8, 0, 1);
        push(32'hA5, 8, 0, 2);
        push(32'h3C, 8, 0, 0);
        tx_en_i = 1'b1;
        check_frame("stop_1p5");
        n_cmp++;
        if (done_idx != 168) begin n_fail++; $display("FAIL stop_1p5 length: got %0d, required 168", done_idx); end
        check_frame("stop_2");
        n_cmp++;
        if (done_idx != 176) begin n_fail++; $display("FAIL stop_2 length: got %0d, required 176", done_idx); end
        n_cmp++;
        if (gap != 1) begin n_fail++; $display("FAIL b2b gap_after_1p5: got %0d ticks, required 1", gap); end
        check_frame("after_stop_2");
        n_cmp++;
        if (gap != 1) begin n_fail++; $display("FAIL b2b gap_after_2: got %0d ticks, required 1", gap); end
        tx_en_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        int d0;
        for (int i = 0; i < 5; i++) begin
            push($urandom_range(0, 511), $urandom_range(5, 9), $urandom_range(0, 3), $urandom_range(0, 2));
            if (i == 3) begin
                n_cmp++;
                if (tx_ready_o !== 1'b0) begin n_fail++; $display("FAIL full ready: got %b, required 0", tx_ready_o); end
            end
        end
        n_cmp++;
        if (fifo_count_o !== 3'(DEPTH)) begin n_fail++; $display("FAIL full count: got %0d, required %0d", fifo_count_o, DEPTH); end
        d0 = done_cnt;
        tx_en_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) check_frame($sformatf("fifo_%0d", i));
        tx_en_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        n_cmp++;
        if (done_cnt - d0 != DEPTH) begin n_fail++; $display("FAIL fifo done_pulses: got %0d, required %0d", done_cnt - d0, DEPTH); end
        n_cmp++;
        if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL fifo drained count: got %0d, required 0", fifo_count_o); end
    endtask

    task automatic test_random();
        int n;
        for (int b = 0; b < 3; b++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++)
                push($urandom_range(0, 511), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
            tx_en_i = 1'b1;
            for (int i = 0; i < n; i++) begin
                check_frame($sformatf("rand_b%0d_f%0d", b, i));
                if (i > 0) begin
                    n_cmp++;
                    if (gap != 1) begin n_fail++; $display("FAIL rand gap b%0d f%0d: got %0d, required 1", b, i, gap); end
                end
            end
            tx_en_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int waited, d0;
        for (int i = 0; i < 3; i++) push(32'h0F0 + i, 9, 1, 0);
        tx_en_i = 1'b1;
        waited = 0;
        do begin next_tick(); waited++; end while (uart_tx_o !== 1'b0 && waited < 3000);
        repeat (40) next_tick();
        tx_en_i = 1'b0;
        d0 = done_cnt;
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid line: got %b, required 1", uart_tx_o); end
        n_cmp++; if (tx_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b, required 0", tx_busy_o); end
        n_cmp++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL rst_mid count: got %0d, required 0", fifo_count_o); end
        mq.delete();
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (60) @(posedge clk_i);
        #1;
        n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL rst_mid done_pulses: got %0d, required 0", done_cnt - d0); end
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid idle line: got %b, required 1", uart_tx_o); end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        int k, d0;
        d0 = done_cnt;
        @(negedge clk_i);
        tx_break_i = 1'b1;
        k = 0;
        do begin next_tick(); k++; end while (uart_tx_o !== 1'b0 && k < 100);
        k = 0;
        do begin
            next_tick();
            k++;
            if (k == 2 * OS) tx_break_i = 1'b0;
            if (k == 100) begin
                n_cmp++;
                if (tx_busy_o !== 1'b1) begin n_fail++; $display("FAIL break busy: got %b, required 1", tx_busy_o); end
            end
        end while (uart_tx_o !== 1'b1 && k < 400);
        n_cmp++;
        if (k != (MAXW + 4) * OS) begin n_fail++; $display("FAIL break low_ticks: got %0d, required %0d", k, (MAXW + 4) * OS); end
        n_cmp++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL break done_pulses: got %0d, required 0", done_cnt - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_width_clamp();
        test_back_to_back();
        test_fifo_full();
        test_random();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Parametrised UART transmitter: next generation of the existing Tx block for the FPGA UART.
- Adds a valid/ready-fed Tx FIFO, runtime-selectable data width (5..MAX_UART_DATA_W) and parity mode (none/even/odd/mark).
- Adds 1, 1.5 or 2 stop bits, a configurable oversample factor, and a registered glitch-free line output.
- Sits between the bus/register interface and the uart_tx pin; shares baud_en_i with the Rx path.

Parameters:
- MAX_UART_DATA_W, 9, maximum data bits per frame; legal range 5..16.
- FIFO_DEPTH, 4, Tx FIFO entries; power of two, >=2.
- OVERSAMPLE, 16, baud_en_i ticks per bit; even, >=4.

Ports:
- clk_i  in  1  top clock
- rst_ni  in  1  asynchronous active-low reset
- baud_en_i  in  1  one-clk tick at OVERSAMPLE x baud rate
- tx_en_i  in  1  permits new frames to start
- tx_valid_i  in  1  write request into FIFO
- tx_ready_o  out  1  FIFO can accept; equals not-full
- tx_data_i  in  MAX_UART_DATA_W  character, LSB sent first
- data_w_i  in  $clog2(MAX_UART_DATA_W+1)  data bits per frame
- parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 mark
- stop_mode_i  in  2  00 = 1 bit, 01 = 1.5 bits, 1x = 2 bits
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries
- tx_busy_o  out  1  frame (or break) in progress
- tx_done_o  out  1  one-clk pulse at end of last stop bit
- uart_tx_o  out  1  serial line, idle high, registered

Behaviour:
- Reset (async assert, sync deassert externally): uart_tx_o=1, tx_busy_o=0, tx_done_o=0, fifo_count_o=0, tx_ready_o=1. FSM to IDLE, counters 0, FIFO emptied.
- Reset mid-frame aborts the frame immediately; the line returns high and no done pulse is issued.
- FIFO push: tx_valid_i && tx_ready_o on a clk edge, independent of baud_en_i. Stores tx_data_i plus data_w_i, parity_mode_i and stop_mode_i as one entry, so config is per character.
- Push while full is ignored; tx_ready_o does not look ahead to a same-cycle pop.
- Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP (plus BREAK with the option). All transitions happen only on baud_en_i edges.
- IDLE -> START: on a tick with tx_en_i=1 and FIFO non-empty.
  - Pop the head entry into frame registers.
  - Drive uart_tx_o=0 on the same edge.
  - Set tx_busy_o=1 and sample_cnt=0.
- Bit period: exactly OVERSAMPLE ticks. The bit ends on the tick where sample_cnt==OVERSAMPLE-1; sample_cnt wraps to 0.
- START -> DATA: bit_cnt=0, line = data[0].
- DATA: line = data[bit_cnt].
  - Leave after bit eff_w-1.
  - eff_w = data_w_i clamped to [5, MAX_UART_DATA_W] (values <5 become 5; values >MAX become MAX).
  - Bits at or above eff_w are ignored.
- DATA -> PARITY if mode != none, else DATA -> STOP.
- PARITY line value, computed over eff_w bits only:
  - even: XOR of the bits.
  - odd: inverted XOR.
  - mark: 1.
- STOP: line=1.
  - Length OVERSAMPLE ticks for 1 bit, 3*OVERSAMPLE/2 for 1.5, 2*OVERSAMPLE for 2.
  - On the final tick: tx_done_o pulses for one clk, tx_busy_o->0, state -> IDLE.
- Back-to-back frames: IDLE may start the next frame on the tick immediately after STOP ends, giving no idle gap between frames.
- tx_en_i deasserted mid-frame: the current frame completes and the FIFO keeps its contents.
- Changes on the config inputs affect only entries pushed after the change.
- All outputs are registers except tx_ready_o and fifo_count_o (derived from FIFO pointers/count register).

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro: adds input tx_break_i (1 bit).
  - In IDLE, a tick with tx_break_i=1 enters BREAK; break has priority over a FIFO pop.
  - In BREAK: uart_tx_o=0 and tx_busy_o=1.
  - BREAK exits to IDLE at the first bit boundary where tx_break_i=0 and at least MAX_UART_DATA_W+4 bit periods have elapsed.
  - No tx_done_o pulse for a break; the FIFO is untouched.
- Without the macro: no port and no BREAK state; the line is low only during start, data or parity bits.

Test Plan:
- Reset, then push 0x55 with data_w=8, parity none, stop 1, OVERSAMPLE=16 -> line shows 0,1,0,1,0,1,0,1,0,1 bits of 16 ticks each. tx_done_o pulses once, 160 ticks after START.
- Push 0x1A3 with data_w=9 and parity even/odd/mark in three frames -> parity bit = 1, 0, 1 respectively; 9 data bits LSB first.
- Push 0xFF with data_w=3, then data_w=12 (MAX=9) -> frames carry 5 and 9 data bits respectively.
- stop_mode 01 then 10 -> stop high for 24 then 32 ticks; the next queued frame's start bit follows with no gap.
- Push 5 entries with FIFO_DEPTH=4 and tx_en_i=0 -> tx_ready_o=0 after 4, fifth push dropped, fifo_count_o=4. Raise tx_en_i -> 4 frames, 4 done pulses.
- Assert rst_ni low mid-DATA -> uart_tx_o=1 and tx_busy_o=0 immediately (no clock needed), fifo_count_o=0. With UART_TX_BREAK_EN, tx_break_i held for 2 bit periods -> line low for 13 bit periods (MAX=9).
